edge_event_scheduler: RTL and testbench
=======================================

Name: edge_event_scheduler

Overview:
- Multi-channel front end that converts N asynchronous level inputs into single-cycle edge events.
- Counts pending events per channel and delivers them one at a time through a valid/ready port.
- A round-robin arbiter shares that single output port among the channels.
- Sits between raw status/button levels and the downstream event consumer. Replaces per-channel level-to-pulse instances when several sources share one consumer.

Parameters:
- N_CH, 4: number of input channels (2..16).
- SYNC_STAGES, 2: synchronizer flops per channel (>=2).
- CNT_W, 3: pending-counter width per channel; saturates at 2^CNT_W-1.
- CH_W, $clog2(N_CH): width of the channel index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted. All flops are cleared immediately on assertion.
- x  in  N_CH  asynchronous level inputs, one bit per channel.
- ch_en  in  N_CH  per-channel edge-capture enable.
- evt_valid  out  1  an event is offered.
- evt_ch  out  CH_W  channel index of the offered event.
- evt_ready  in  1  consumer accepts the event.
- ovf  out  N_CH  sticky per-channel overflow flags.
- ovf_clr  in  N_CH  clears the corresponding ovf bits.
- busy  out  1  any pending count is nonzero, or evt_valid is high.

Behaviour:
- Reset values: evt_valid=0, evt_ch=0, ovf=0, busy=0. Also cleared: all synchronizer flops, previous-level flops (x_pre), pending counters, rr_ptr=0, FSM=IDLE.
- Synchronizer: x[i] passes through SYNC_STAGES flops to give xs[i]; x_pre[i] <= xs[i].
- Rise detect: rise[i] = xs[i] & ~x_pre[i] & ch_en[i]. Combinational; counted at the next clock edge.
- Power-on: a channel already high when reset is released produces exactly one rise event.
- Pending counter cnt[i], evaluated each cycle:
  - rise only: +1.
  - accept of channel i only: -1.
  - rise and accept in the same cycle: unchanged.
  - rise while cnt[i]==max with no accept: cnt stays at max and ovf[i] is set.
  - ovf[i] stays set until ovf_clr[i]=1. If set and clear coincide, set wins.
- Accept = evt_valid & evt_ready.
- ch_en=0 blocks only new captures. Already-pending events on that channel are still delivered.
- FSM, two states:
  - IDLE: evt_valid=0. If any cnt!=0, select the first nonzero channel searching upward from rr_ptr with wrap-around. Register evt_ch=<selected>, evt_valid=1, go to OFFER.
  - OFFER: evt_valid=1; evt_ch is held stable regardless of ready.
  - OFFER on accept: decrement cnt[evt_ch], rr_ptr <= (evt_ch+1) mod N_CH, go to IDLE.
  - Throughput: at most one event per 2 cycles (one mandatory IDLE bubble).
- Valid/ready rules: evt_valid never drops without an accept. evt_ch never changes while evt_valid=1.
- Latency: x rises before edge 1 and the channel is idle → cnt increments at edge SYNC_STAGES+1 → evt_valid=1 after edge SYNC_STAGES+2.
- Fairness: with all channels continuously pending, grants rotate 0,1,..,N_CH-1,0,...
- busy is combinational: OR of (cnt!=0) over all channels, ORed with evt_valid.
- Reset asserted mid-operation: all pending events are discarded and evt_valid drops asynchronously.
- Falling edges generate no event (unless the optional feature is compiled in).

Optional Feature:
- Macro: EDGE_SCHED_BOTH_EDGES_EN.
- Defined: event = (xs[i]^x_pre[i]) & ch_en[i], so both rising and falling edges count. Adds output evt_lvl (1 bit), registered with evt_ch, equal to xs of the granted channel at the time its oldest pending event was captured. This requires a per-channel FIFO of level bits of depth 2^CNT_W-1; on overflow the new level bit is dropped.
- Undefined: rising edges only; no evt_lvl port.

Test Plan:
- Reset release with x=4'b0010, ready=1 → one event, evt_ch=1, at cycle SYNC_STAGES+2. Then busy=0, and no further events while x is held.
- x[0] pulses 3 times (4 cycles high / 4 low), ready=0 → cnt[0]=3. Raise ready → three accepts on ch 0, each separated by one idle cycle, then busy=0.
- Edges on ch 0,2,3 in the same cycle, ready=1 → grant order 0,2,3. Then a second burst on ch 0,2 with rr_ptr=0 → order 0,2. evt_ch stays stable while ready=0 for 5 cycles.
- 9 rising edges on ch 1 with ready=0 (CNT_W=3) → cnt saturates at 7 and ovf[1]=1. ovf_clr[1] pulse → ovf[1]=0. Exactly 7 events are drained.
- ch_en[2]=0 with 2 edges on ch 2 → no events. With 1 pending event, drop ch_en → that event is still delivered.
- Assert reset with evt_valid=1 and cnt[3]=4 → evt_valid=0 immediately. After release, no events appear while x is held low.

Source files
------------

// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler: per-channel edge capture with pending counters, drained round-robin through one valid/ready port.
// Optional build macro EDGE_SCHED_BOTH_EDGES_EN counts both edges and adds evt_lvl. Rev 1.0
`default_nettype none

module edge_event_scheduler #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int CH_W        = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] x,
  input  logic [N_CH-1:0] ch_en,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  input  logic            evt_ready,
`ifdef EDGE_SCHED_BOTH_EDGES_EN
  output logic            evt_lvl,
`endif
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CH_W-1:0] evt_ch_nxt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] rr_ptr_nxt;
  logic [CH_W-1:0] sel_lo;
  logic [CH_W-1:0] sel_hi;
  logic [CH_W-1:0] sel_ch;
  logic            hi_any;
  logic            accept;
  logic [N_CH-1:0] xs;
  logic [N_CH-1:0] x_pre;
  logic [N_CH-1:0] evt_det;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] accept_ch;
`ifdef EDGE_SCHED_BOTH_EDGES_EN
  logic [N_CH-1:0] lvl_head;
`endif

  assign evt_valid = (state == OFFER);
  assign accept    = evt_valid & evt_ready;
  assign busy      = (|pend) | evt_valid;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   pre_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;
    logic                   sat_hit;

    assign xs[i]        = sync[SYNC_STAGES-1];
    assign x_pre[i]     = pre_q;
    assign pend[i]      = (cnt_q != '0);
    assign ovf[i]       = ovf_q;
    assign accept_ch[i] = accept && (evt_ch == CH_W'(i));
`ifdef EDGE_SCHED_BOTH_EDGES_EN
    assign evt_det[i]   = (xs[i] ^ pre_q) & ch_en[i];
`else
    assign evt_det[i]   = xs[i] & ~pre_q & ch_en[i];
`endif
    // A capture that cannot be counted (full, nothing leaving) flags overflow instead.
    assign sat_hit      = evt_det[i] && !accept_ch[i] && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync  <= '0;
        pre_q <= 1'b0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        sync  <= {sync[SYNC_STAGES-2:0], x[i]};
        pre_q <= xs[i];
        if (evt_det[i] && !accept_ch[i] && !sat_hit) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (!evt_det[i] && accept_ch[i]) begin
          cnt_q <= cnt_q - 1'b1;
        end
        if (sat_hit) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr[i]) begin
          ovf_q <= 1'b0;
        end
      end
    end

`ifdef EDGE_SCHED_BOTH_EDGES_EN
    localparam int DEPTH = (1 << CNT_W) - 1;
    logic [DEPTH-1:0] lvl_q;
    logic [DEPTH-1:0] lvl_nxt;

    // Shift-register FIFO: slot 0 is the oldest level, occupancy equals cnt_q.
    always_comb begin
      lvl_nxt = lvl_q;
      if (accept_ch[i]) begin
        lvl_nxt = lvl_q >> 1;
      end
      if (evt_det[i]) begin
        if (accept_ch[i]) begin
          lvl_nxt[cnt_q - 1'b1] = xs[i];
        end else if (cnt_q != CNT_MAX) begin
          lvl_nxt[cnt_q] = xs[i];
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lvl_q <= '0;
      end else begin
        lvl_q <= lvl_nxt;
      end
    end

    assign lvl_head[i] = lvl_q[0];
`endif
  end

  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    hi_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_lo = CH_W'(i);
      end
      if (pend[i] && (CH_W'(i) >= rr_ptr)) begin
        sel_hi = CH_W'(i);
        hi_any = 1'b1;
      end
    end
    sel_ch = hi_any ? sel_hi : sel_lo;
  end

  always_comb begin
    state_nxt  = state;
    evt_ch_nxt = evt_ch;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt  = OFFER;
          evt_ch_nxt = sel_ch;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      evt_ch <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      evt_ch <= evt_ch_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

`ifdef EDGE_SCHED_BOTH_EDGES_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_lvl <= 1'b0;
    end else if ((state == IDLE) && (|pend)) begin
      evt_lvl <= lvl_head[sel_ch];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_event_scheduler.sv
// tb_edge_event_scheduler: directed scenarios plus randomized traffic against a cycle-level reference model.
`default_nettype none

module tb_edge_event_scheduler;
  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 3;
  localparam int CH_W        = 2;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N_CH-1:0] x = '0;
  logic [N_CH-1:0] ch_en = '1;
  logic [N_CH-1:0] ovf_clr = '0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic [N_CH-1:0] ovf;
  logic            busy;
`ifdef EDGE_SCHED_BOTH_EDGES_EN
  logic            evt_lvl;
`endif

  int checks = 0;
  int failures = 0;

  edge_event_scheduler #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .ch_en(ch_en),
    .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_ready(evt_ready),
`ifdef EDGE_SCHED_BOTH_EDGES_EN
    .evt_lvl(evt_lvl),
`endif
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending counts per channel, one offered event, round-robin pointer.
  int              m_cnt[N_CH];
  bit [N_CH-1:0]   m_ovf;
  bit              m_valid;
  int              m_ch;
  int              m_ptr;
  logic [N_CH-1:0] xh[$];
  int              grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_ch    = 0;
    m_ptr   = 0;
    xh      = {};
    for (int k = 0; k <= SYNC_STAGES; k++) xh.push_back('0);
  endtask

  function automatic bit m_busy();
    bit b;
    b = m_valid;
    for (int i = 0; i < N_CH; i++) if (m_cnt[i] != 0) b = 1'b1;
    return b;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [N_CH-1:0] xs_m;
    logic [N_CH-1:0] xp_m;
    logic [N_CH-1:0] ev;
    bit              acc;
    bit              mine;
    bit              full;
    int              sel;
    if (!reset) return;
    xs_m = xh[SYNC_STAGES-1];
    xp_m = xh[SYNC_STAGES];
`ifdef EDGE_SCHED_BOTH_EDGES_EN
    ev = (xs_m ^ xp_m) & ch_en;
`else
    ev = xs_m & ~xp_m & ch_en;
`endif
    acc = m_valid && evt_ready;
    sel = -1;
    if (!m_valid)
      for (int k = 0; k < N_CH; k++)
        if (sel < 0 && m_cnt[(m_ptr + k) % N_CH] != 0) sel = (m_ptr + k) % N_CH;
    for (int i = 0; i < N_CH; i++) begin
      mine = acc && (m_ch == i);
      full = ev[i] && !mine && (m_cnt[i] == CMAX);
      if (full) m_ovf[i] = 1'b1;
      else if (ovf_clr[i]) m_ovf[i] = 1'b0;
      if (ev[i] && !mine && !full) m_cnt[i]++;
      else if (!ev[i] && mine) m_cnt[i]--;
    end
    if (m_valid) begin
      if (acc) begin
        m_valid = 1'b0;
        m_ptr   = (m_ch + 1) % N_CH;
      end
    end else if (sel >= 0) begin
      m_valid = 1'b1;
      m_ch    = sel;
    end
    xh.push_front(x);
    xh.delete(SYNC_STAGES + 1);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", 32'(evt_valid), 32'(m_valid));
    chk("ch", 32'(evt_ch), 32'(m_ch));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("busy", 32'(busy), 32'(m_busy()));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (evt_valid && evt_ready) grants.push_back(int'(evt_ch));
      step();
    end
  endtask

  initial begin
    int lat;
    int n1;
    int exp3[3];
    exp3 = '{0, 2, 3};
    model_reset();
    x = 4'b0010;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    run(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Power-on high channel yields exactly one event after SYNC_STAGES+2 edges.
    reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (evt_valid) begin
        lat = k;
        break;
      end
    end
    chk("t1_latency", 32'(lat), 32'(SYNC_STAGES + 2));
    chk("t1_ch", 32'(evt_ch), 32'd1);
    grants = {};
    run(12);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_no_more", 32'(grants.size()), 32'd1);

    // Three pulses on ch0 while stalled, then drained.
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      x[0] = 1'b1; run(4);
      x[0] = 1'b0; run(4);
    end
    run(4);
    chk("t2_pending_ch", 32'(evt_ch), 32'd0);
    grants = {};
    evt_ready = 1'b1;
    run(20);
    chk("t2_count", 32'(grants.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("t2_grant_ch", 32'(grants[k]), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // Simultaneous edges after reset: round-robin order from pointer 0.
    reset = 1'b0; model_reset();
    x = '0;
    run(2);
    reset = 1'b1;
    run(4);
    x = 4'b1101;
    grants = {};
    run(12);
    chk("t3_count", 32'(grants.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("t3_order", 32'(grants[k]), 32'(exp3[k]));
    x = '0; run(6);
    evt_ready = 1'b0;
    x = 4'b0101;
    run(6);
    chk("t3_offer_ch", 32'(evt_ch), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_ch", 32'(evt_ch), 32'd0);
      chk("t3_hold_valid", 32'(evt_valid), 32'd1);
    end
    grants = {};
    evt_ready = 1'b1;
    run(10);
    chk("t3b_count", 32'(grants.size()), 32'd2);
    chk("t3b_first", 32'(grants[0]), 32'd0);
    chk("t3b_second", 32'(grants[1]), 32'd2);

    // Saturation and sticky overflow on ch1.
    x = '0; run(6);
    evt_ready = 1'b0;
    for (int p = 0; p < 9; p++) begin
      x[1] = 1'b1; run(2);
      x[1] = 1'b0; run(2);
    end
    run(4);
    chk("t4_ovf_set", 32'(ovf[1]), 32'd1);
    ovf_clr = 4'b0010; run(1);
    ovf_clr = '0;
    chk("t4_ovf_clr", 32'(ovf[1]), 32'd0);
    grants = {};
    evt_ready = 1'b1;
    run(30);
    chk("t4_drained", 32'(grants.size()), 32'd7);
    n1 = 0;
    foreach (grants[k]) if (grants[k] == 1) n1++;
    chk("t4_all_ch1", 32'(n1), 32'd7);

    // Disabled channel captures nothing but still delivers what is pending.
    ch_en = 4'b1011;
    grants = {};
    for (int p = 0; p < 2; p++) begin
      x[2] = 1'b1; run(2);
      x[2] = 1'b0; run(2);
    end
    run(8);
    chk("t5_blocked", 32'(grants.size()), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    ch_en = '1;
    evt_ready = 1'b0;
    x[2] = 1'b1;
    run(6);
    ch_en = 4'b1011;
    grants = {};
    evt_ready = 1'b1;
    run(6);
    chk("t5_delivered", 32'(grants.size()), 32'd1);
    chk("t5_ch", 32'(grants[0]), 32'd2);
    x[2] = 1'b0;
    ch_en = '1;
    run(6);

    // Reset asserted mid-offer drops everything at once.
    evt_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      x[3] = 1'b1; run(2);
      x[3] = 1'b0; run(2);
    end
    run(4);
    chk("t6_pre_valid", 32'(evt_valid), 32'd1);
    chk("t6_pre_ch", 32'(evt_ch), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(evt_valid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk); #1;
    run(3);
    reset = 1'b1;
    grants = {};
    evt_ready = 1'b1;
    run(12);
    chk("t6_no_events", 32'(grants.size()), 32'd0);

    // Randomized traffic: slow consumer first, then a fast one.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) x[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      if (c < 300) evt_ready = ($urandom_range(0, 3) == 0);
      else evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) ch_en = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      if ($urandom_range(0, 49) == 0) ch_en = '1;
      ovf_clr = ($urandom_range(0, 15) == 0) ? N_CH'($urandom_range(0, (1 << N_CH) - 1)) : '0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
